credit_manager: RTL and testbench



---
 rtl/credit_manager.sv | 90 +++++++++
 tb/tb_credit_manager.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/credit_manager.sv
// Credit bookkeeping for the arcade front end: saturating coin count, start-edge
// detection with credit deduction, game-start handshake and BCD credit digits.
module credit_manager #(
  parameter int MAX_CREDITS      = 99,
  parameter int CREDITS_PER_GAME = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_addCoin,
  input  logic       i_startBtn,
  input  logic       i_gameOver,
  output logic [6:0] o_credits,
  output logic [3:0] o_creditsTens,
  output logic [3:0] o_creditsOnes,
  output logic       o_coinAccepted,
  output logic       o_startGame,
  output logic       o_inGame
);

  localparam logic [6:0] MAX_C = 7'(MAX_CREDITS);
  localparam logic [6:0] CPG_C = 7'(CREDITS_PER_GAME);

  typedef enum logic [1:0] {IDLE, READY, PLAYING} state_t;

  state_t     state_q, state_d;
  logic [6:0] count_q, count_d, count_plus;
  logic       start_prev_q;
  logic       coin_ok, start_ev, start_ok;
  logic       coin_acc_q, coin_acc_d;
  logic       start_game_q, start_game_d;
  logic       in_game_q, in_game_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;

  // State register plus all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      start_prev_q <= 1'b1;
      coin_acc_q   <= 1'b0;
      start_game_q <= 1'b0;
      in_game_q    <= 1'b0;
      tens_q       <= '0;
      ones_q       <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      start_prev_q <= i_startBtn;
      coin_acc_q   <= coin_acc_d;
      start_game_q <= start_game_d;
      in_game_q    <= in_game_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
    end
  end

  // Next-state logic; coin saturation and start eligibility both use the pre-edge count.
  always_comb begin
    coin_ok    = !i_addCoin && (count_q < MAX_C);
    count_plus = count_q + {6'd0, coin_ok};
    start_ev   = start_prev_q && !i_startBtn;
    start_ok   = (state_q == READY) && start_ev;
    state_d    = state_q;
    case (state_q)
      IDLE:    if (count_plus >= CPG_C) state_d = READY;
      READY:   if (start_ev) state_d = PLAYING;
      PLAYING: if (i_gameOver) state_d = (count_plus >= CPG_C) ? READY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    count_d      = start_ok ? (count_plus - CPG_C) : count_plus;
    coin_acc_d   = coin_ok;
    start_game_d = start_ok;
    in_game_d    = (state_d == PLAYING);
    // BCD is taken from the current register, so digits trail the count by a cycle.
    tens_d       = 4'(count_q / 7'd10);
    ones_d       = 4'(count_q % 7'd10);
  end

  assign o_credits      = count_q;
  assign o_creditsTens  = tens_q;
  assign o_creditsOnes  = ones_q;
  assign o_coinAccepted = coin_acc_q;
  assign o_startGame    = start_game_q;
  assign o_inGame       = in_game_q;

endmodule

// File: tb/tb_credit_manager.sv
// Self-checking bench for credit_manager: behavioural credit/game model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_credit_manager;
  localparam int MAXC = 99;
  localparam int CPG  = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_addCoin, i_startBtn, i_gameOver;
  logic [6:0] o_credits;
  logic [3:0] o_creditsTens, o_creditsOnes;
  logic       o_coinAccepted, o_startGame, o_inGame;

  int checks = 0;
  int failures = 0;

  credit_manager #(.MAX_CREDITS(MAXC), .CREDITS_PER_GAME(CPG)) dut (
    .clk(clk), .reset(reset), .i_addCoin(i_addCoin), .i_startBtn(i_startBtn),
    .i_gameOver(i_gameOver), .o_credits(o_credits), .o_creditsTens(o_creditsTens),
    .o_creditsOnes(o_creditsOnes), .o_coinAccepted(o_coinAccepted),
    .o_startGame(o_startGame), .o_inGame(o_inGame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a game can start when not playing, enough credits, and the button just went low.
  int m_cred, m_bcd_src, m_play, m_prev_btn, m_acc, m_start;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cred <= 0; m_bcd_src <= 0; m_play <= 0; m_prev_btn <= 1; m_acc <= 0; m_start <= 0;
    end else begin
      int coin, st;
      coin = (!i_addCoin && m_cred < MAXC) ? 1 : 0;
      st   = (m_prev_btn == 1 && !i_startBtn && m_play == 0 && m_cred >= CPG) ? 1 : 0;
      m_cred    <= m_cred + coin - (st == 1 ? CPG : 0);
      m_bcd_src <= m_cred;
      m_acc     <= coin;
      m_start   <= st;
      m_prev_btn <= i_startBtn ? 1 : 0;
      if (st == 1) m_play <= 1;
      else if (m_play == 1 && i_gameOver) m_play <= 0;
    end
  end

  always @(negedge clk) begin
    chk("credits", int'(o_credits), m_cred);
    chk("bcd_tens", int'(o_creditsTens), m_bcd_src / 10);
    chk("bcd_ones", int'(o_creditsOnes), m_bcd_src % 10);
    chk("coin_accepted", int'(o_coinAccepted), m_acc);
    chk("start_game", int'(o_startGame), m_start);
    chk("in_game", int'(o_inGame), m_play);
  end

  // Apply inputs, let one edge sample them, return 2 time units after that edge.
  task automatic drive(input logic coin_n, input logic btn_n, input logic go);
    i_addCoin = coin_n; i_startBtn = btn_n; i_gameOver = go;
    @(posedge clk); #2;
    $display("t=%0t coin_n=%0b btn_n=%0b go=%0b -> credits=%0d bcd=%0d%0d acc=%0b start=%0b ingame=%0b",
             $time, coin_n, btn_n, go, o_credits, o_creditsTens, o_creditsOnes,
             o_coinAccepted, o_startGame, o_inGame);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    reset = 1'b1; i_addCoin = 1'b1; i_startBtn = 1'b1; i_gameOver = 1'b0;
    #1;
    chk("reset_credits", int'(o_credits), 0);
    chk("reset_ingame", int'(o_inGame), 0);
    #11 reset = 1'b0;

    // Three coins.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      chk("coin_pulse", int'(o_coinAccepted), 1);
      chk("coin_count", int'(o_credits), i + 1);
    end
    drive(1'b1, 1'b1, 1'b0);
    chk("coin_pulse_drop", int'(o_coinAccepted), 0);
    chk("bcd_ones_3", int'(o_creditsOnes), 3);
    chk("bcd_tens_0", int'(o_creditsTens), 0);

    // Hold start 20 cycles: exactly one start.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      pulses += int'(o_startGame);
    end
    chk("hold_one_start", pulses, 1);
    chk("start_deduct", int'(o_credits), 2);
    chk("start_ingame", int'(o_inGame), 1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("press_in_play_ignored", int'(o_startGame), 0);
    drive(1'b1, 1'b1, 1'b1);
    chk("gameover_ingame", int'(o_inGame), 0);

    // Start from 2 -> 1, game over, start again 1 -> 0, game over to IDLE.
    drive(1'b1, 1'b0, 1'b0);
    chk("start2", int'(o_startGame), 1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    chk("start3_credits", int'(o_credits), 0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    chk("start_no_credit", int'(o_startGame), 0);
    chk("idle_no_game", int'(o_inGame), 0);
    drive(1'b1, 1'b1, 1'b1);

    // 1 credit, coin and start edge together.
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("simul_credits", int'(o_credits), 1);
    chk("simul_start", int'(o_startGame), 1);
    chk("simul_coin", int'(o_coinAccepted), 1);
    // Coin together with game over: post-coin count 2 -> READY.
    drive(1'b0, 1'b1, 1'b1);
    chk("coin_gameover_credits", int'(o_credits), 2);
    drive(1'b1, 1'b0, 1'b0);
    chk("ready_after_gameover", int'(o_startGame), 1);
    drive(1'b1, 1'b1, 1'b1);

    // Saturation: 100 coins from 0.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      pulses += int'(o_coinAccepted);
    end
    chk("sat_last_no_pulse", int'(o_coinAccepted), 0);
    chk("sat_pulses", pulses, 99);
    chk("sat_credits", int'(o_credits), 99);
    drive(1'b1, 1'b1, 1'b0);
    chk("sat_tens", int'(o_creditsTens), 9);
    chk("sat_ones", int'(o_creditsOnes), 9);

    // Mid-game reset with 5 credits, button held across release.
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("pre_reset_credits", int'(o_credits), 5);
    chk("pre_reset_ingame", int'(o_inGame), 1);
    reset = 1'b1;
    #1;
    chk("async_credits", int'(o_credits), 0);
    chk("async_ingame", int'(o_inGame), 0);
    chk("async_tens", int'(o_creditsTens), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    pulses = 0;
    drive(1'b1, 1'b0, 1'b0);
    pulses += int'(o_startGame);
    drive(1'b0, 1'b0, 1'b0);
    pulses += int'(o_startGame);
    drive(1'b1, 1'b0, 1'b0);
    pulses += int'(o_startGame);
    chk("held_no_start", pulses, 0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("repress_start", int'(o_startGame), 1);
    chk("repress_credits", int'(o_credits), 0);
    drive(1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
